// File: rtl/inst_buf_if.sv
// inst_buf_if: decode-to-dispatch bus of the dual-lane instruction buffer
interface inst_buf_if #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 255
);
   logic                   flush;
   logic                   stall;
   logic                   in_valid0;
   logic                   in_valid1;
   logic [ENTRY_W-1:0]     in_data0;
   logic [ENTRY_W-1:0]     in_data1;
   logic                   in_ready;
   logic                   out_valid0;
   logic                   out_valid1;
   logic [ENTRY_W-1:0]     out_data0;
   logic [ENTRY_W-1:0]     out_data1;
   logic [1:0]             pop_cnt;
   logic [$clog2(DEPTH):0] count;
   modport master (
      output flush, stall, in_valid0, in_valid1, in_data0, in_data1, pop_cnt,
      input  in_ready, out_valid0, out_valid1, out_data0, out_data1, count
   );
   modport slave (
      input  flush, stall, in_valid0, in_valid1, in_data0, in_data1, pop_cnt,
      output in_ready, out_valid0, out_valid1, out_data0, out_data1, count
   );
endinterface

// File: rtl/inst_buf.sv
// inst_buf: dual-lane circular instruction buffer between decode and dispatch.
// Optional INST_BUF_BYPASS_EN: when empty, incoming lanes reach dispatch in the same cycle.
module inst_buf #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 255
) (
   input logic       clk,
   input logic       rst,
   inst_buf_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [AW:0]        count_q, count_d, avail;
   logic               push_en, byp;
   logic [1:0]         push_n, pop_req, pop_eff, skip, wr_n;
   logic [ENTRY_W-1:0] lane0, lane1, wr0;
   assign bus.in_ready = count_q <= (AW+1)'(DEPTH - 2);
   assign push_en      = bus.in_ready & ~bus.flush & ~rst;
   assign push_n       = push_en ? {1'b0, bus.in_valid0} + {1'b0, bus.in_valid1} : 2'd0;
   assign lane0        = bus.in_valid0 ? bus.in_data0 : bus.in_data1;
   assign lane1        = bus.in_data1;
   assign bus.count    = count_q;
`ifdef INST_BUF_BYPASS_EN
   assign byp = (count_q == '0) & ~bus.flush;
`else
   assign byp = 1'b0;
`endif
   // Clamp the pop to what dispatch can see; bypassed lanes it consumes are never stored.
   always_comb begin
      pop_req = bus.pop_cnt[1] ? 2'd2 : bus.pop_cnt;
      avail   = byp ? (AW+1)'(push_n) : count_q;
      pop_eff = (bus.stall | bus.flush) ? 2'd0 : (avail >= (AW+1)'(pop_req)) ? pop_req : avail[1:0];
      skip    = byp ? pop_eff : 2'd0;
      wr_n    = push_n - skip;
      wr0     = skip[0] ? lane1 : lane0;
      head_d  = bus.flush ? '0 : head_q + AW'(pop_eff - skip);
      tail_d  = bus.flush ? '0 : tail_q + AW'(wr_n);
      count_d = bus.flush ? '0 : count_q + (AW+1)'(wr_n) - (AW+1)'(pop_eff - skip);
   end
   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   // Compacted lanes land at tail and tail+1; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_n != 2'd0) mem_q[tail_q] <= wr0;
      if (wr_n == 2'd2) mem_q[tail_q + AW'(1)] <= lane1;
   end
   // Present head/head+1, or the live lanes while bypassing an empty buffer; idle lanes read zero.
   always_comb begin
      bus.out_valid0 = byp ? push_n != 2'd0 : count_q != '0;
      bus.out_valid1 = byp ? push_n == 2'd2 : count_q >= (AW+1)'(2);
      bus.out_data0  = !bus.out_valid0 ? '0 : byp ? lane0 : mem_q[head_q];
      bus.out_data1  = !bus.out_valid1 ? '0 : byp ? lane1 : mem_q[head_q + AW'(1)];
   end
endmodule

// File: doc/inst_buf.md
INST_BUF -- requirements
Module: inst_buf

Interface
REQ-001 Parameter DEPTH, default 8, meaning entry count; SHALL be a power of two and at least 4.
REQ-002 Parameter ENTRY_W, default 255, meaning per-lane payload width: {pre64, excp_arg16, rd5, rj5, rk5, control32, imm32, npc32, ir32, pc32}, MSB to LSB.
REQ-003 Port clk, input, 1, sole clock; one clock; reset is synchronous and active-high.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port flush, input, 1, discard all contents.
REQ-006 Port stall, input, 1, backend stall; blocks pops only.
REQ-007 Ports in_valid0 and in_valid1, input, 1 each, decode lane valids; lane 0 is older.
REQ-008 Ports in_data0 and in_data1, input, ENTRY_W each, decode lane payloads.
REQ-009 Port in_ready, output, 1, buffer can accept two entries this cycle.
REQ-010 Ports out_valid0 and out_valid1, output, 1 each, head and head+1 present to dispatch.
REQ-011 Ports out_data0 and out_data1, output, ENTRY_W each, head and head+1 payloads.
REQ-012 Port pop_cnt, input, 2, entries consumed by dispatch this cycle (0, 1 or 2).
REQ-013 Port count, output, log2(DEPTH)+1, current occupancy.

Function
REQ-014 Storage SHALL be a circular array with head pointer, tail pointer and occupancy counter; both pointers wrap modulo DEPTH.
REQ-015 in_ready SHALL be 1 iff DEPTH-count >= 2; it is a function of registered state only.
REQ-016 Push condition: in_ready & !flush & !rst.
  - in_valid0 & in_valid1: write 2 entries, lane 0 first.
  - Exactly one lane valid: write 1 entry from that lane; lane 1 alone is compacted into the next slot.
REQ-017 Effective pop count SHALL be min(pop_cnt, count), with 3 treated as 2, and forced to 0 when stall or flush is 1.
REQ-018 Each cycle, count SHALL update as count + pushes - effective pops; the head pointer advances by effective pops and the tail pointer by pushes.
REQ-019 out_valid0 = (count>=1) and out_valid1 = (count>=2); out_data0 = entry[head] and out_data1 = entry[head+1 mod DEPTH].
REQ-020 An output data lane SHALL be all-zero whenever its valid is 0.
REQ-021 Latency: an entry pushed at edge N SHALL first appear on the outputs in the cycle after edge N.
REQ-022 Simultaneous push and pop at full-minus-2 occupancy, or at wrap-around, SHALL preserve FIFO order with no entry lost or duplicated.
REQ-023 When flush=1, count, head and tail SHALL be 0 after the next edge, and that cycle's push is discarded; flush dominates both push and pop.
REQ-024 stall=1 with pushes pending SHALL still accept the pushes while in_ready=1.

Reset
REQ-025 On rst=1 at an edge, head, tail and count SHALL be 0, so out_valid0=out_valid1=0, out_data0=out_data1=0, count=0 and in_ready=1; storage contents need not be cleared.
REQ-026 rst asserted mid-operation SHALL behave as REQ-025 regardless of flush, stall or push inputs.

Configuration
REQ-027 Macro INST_BUF_BYPASS_EN: when defined and count==0 with flush=0, incoming valid lanes SHALL drive out_valid* and out_data* combinationally in the same cycle.
  - Of those bypassed entries, only the ones not covered by the effective pop are written to storage.
  - When the macro is undefined, outputs come only from storage, per REQ-021.

Verification
REQ-028 Reset, then push 2 entries with pc 0x1c000000 and 0x1c000004 with pop_cnt=0 -> next cycle out_valid0=out_valid1=1, out_data pc fields 0x1c000000/0x1c000004, count=2.
REQ-029 Push pairs until count=6 with DEPTH=8 -> in_ready=1; push one more pair -> count=8, in_ready=0; a further push attempt -> count stays 8.
REQ-030 count=3, pop_cnt=1, stall=1 -> count stays 3; then stall=0 -> count=2, and the former head+1 is now on out_data0.
REQ-031 count=1, pop_cnt=2 -> count=0 and out_valid0=0; push with lane 1 only valid, carrying pc 0x40 -> next cycle out_valid0=1 with pc 0x40 and out_valid1=0.
REQ-032 Fill to count=7 across the wrap (head=5), flush=1 together with a push -> next cycle count=0, in_ready=1, outputs zero.
REQ-033 With INST_BUF_BYPASS_EN defined, count=0, push a pair with pop_cnt=1 -> same cycle out_data0 = in_data0; next cycle count=1 and out_data0 = previous in_data1.
